// File: rtl/ones_cnt_pkg.sv
// ones_cnt_pkg: shared widths, FSM states and popcount helper for the ones serializer
package ones_cnt_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_TOT_W = 16;
  localparam int MAX_W = 64;
  typedef enum logic {IDLE, SHIFT} state_t;
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction
  function automatic logic [6:0] popcount(input logic [MAX_W-1:0] v);
    popcount = '0;
    for (int i = 0; i < MAX_W; i++) popcount = popcount + 7'(v[i]);
  endfunction
endpackage

// File: rtl/ones_popcount.sv
// ones_popcount: combinational ones count of one WIDTH-bit word
module ones_popcount
  import ones_cnt_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic [WIDTH-1:0] word,
  output logic [CNT_W-1:0] ones
);
  assign ones = CNT_W'(popcount(MAX_W'(word)));
endmodule

// File: rtl/ones_stream_serializer.sv
// ones_stream_serializer: valid/ready word intake shifted out LSB-first with popcount and running total
module ones_stream_serializer
  import ones_cnt_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = cnt_w(WIDTH),
  parameter int TOT_W = DEF_TOT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             bit_out,
  output logic             bit_valid,
  output logic             bit_last,
  output logic [CNT_W-1:0] word_ones,
  output logic [TOT_W-1:0] total_ones,
  input  logic             clear_total,
  output logic             busy
);
  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);
  state_t state, state_n;
  logic [WIDTH-1:0] sh, sh_n, hold, hold_n, load_word;
  logic [IW-1:0] idx, idx_n;
  logic hold_valid, hold_valid_n, accept, last, load;
  logic [CNT_W-1:0] load_ones;
  assign in_ready = reset && !hold_valid;
  assign accept = in_valid && in_ready;
  assign bit_valid = state == SHIFT;
  assign bit_out = sh[0];
  assign last = bit_valid && idx == LAST_IDX;
  assign bit_last = last;
  assign busy = bit_valid || hold_valid;
  // a waiting word always has priority; in_ready is low whenever hold is full
  assign load_word = hold_valid ? hold : in_data;
  ones_popcount #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_pop (
    .word(load_word),
    .ones(load_ones)
  );
  always_comb begin
    load = state == IDLE ? accept : last && (hold_valid || accept);
    state_n = (state == IDLE) ? (accept ? SHIFT : IDLE) : (last && !load ? IDLE : SHIFT);
    sh_n = load ? load_word : sh >> 1;
    idx_n = (load || last || !bit_valid) ? '0 : idx + IW'(1);
    hold_valid_n = (hold_valid || accept) && !load;
    hold_n = (accept && !load) ? in_data : hold;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      sh <= '0;
      idx <= '0;
      hold <= '0;
      hold_valid <= 1'b0;
      word_ones <= '0;
      total_ones <= '0;
    end else begin
      state <= state_n;
      sh <= sh_n;
      idx <= idx_n;
      hold <= hold_n;
      hold_valid <= hold_valid_n;
      if (load) word_ones <= load_ones;
      total_ones <= clear_total ? '0 :
                    (bit_valid && bit_out && total_ones != '1) ? total_ones + TOT_W'(1) : total_ones;
    end
  end
endmodule

// File: tb/tb_ones_stream_serializer.sv
// tb_ones_stream_serializer: directed scenarios plus random traffic against a bit-queue reference model
module tb_ones_stream_serializer;
  localparam int W = 8;
  logic clk = 0, reset = 0, in_valid = 0, clear_total = 0;
  logic [W-1:0] in_data = '0;
  logic in_ready, bit_out, bit_valid, bit_last, busy;
  logic [3:0] word_ones;
  logic [15:0] total_ones;
  logic r4 = 0, v4 = 0, c4 = 0;
  logic [W-1:0] d4 = '0;
  logic o4_ready, o4_out, o4_valid, o4_last, o4_busy;
  logic [3:0] o4_wones, o4_total;
  int vectors = 0, errors = 0;

  always #5 clk = ~clk;

  ones_stream_serializer dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .bit_out(bit_out), .bit_valid(bit_valid), .bit_last(bit_last), .word_ones(word_ones),
    .total_ones(total_ones), .clear_total(clear_total), .busy(busy)
  );

  ones_stream_serializer #(.TOT_W(4)) dut4 (
    .clk(clk), .reset(r4), .in_data(d4), .in_valid(v4), .in_ready(o4_ready),
    .bit_out(o4_out), .bit_valid(o4_valid), .bit_last(o4_last), .word_ones(o4_wones),
    .total_ones(o4_total), .clear_total(c4), .busy(o4_busy)
  );

  // Reference: every accepted word appends its WIDTH bits to a queue; one bit leaves per clock.
  typedef struct {logic b; logic last; logic first; int ones;} ent_t;
  ent_t q[$];
  int m_total = 0, m_wones = 0;
  logic m_acc, m_bit;

  function automatic int pending();
    int n = 0;
    for (int i = 1; i < q.size(); i++) if (q[i].first) n++;
    return n;
  endfunction

  function automatic logic m_ready();
    return reset && pending() == 0;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      q.delete();
      m_total = 0;
      m_wones = 0;
    end else begin
      m_acc = in_valid && pending() == 0;
      m_bit = q.size() != 0 && q[0].b;
      if (q.size() != 0) void'(q.pop_front());
      m_total = clear_total ? 0 : (m_bit && m_total < 65535) ? m_total + 1 : m_total;
      if (m_acc)
        for (int i = 0; i < W; i++) q.push_back('{in_data[i], i == W - 1, i == 0, $countones(in_data)});
      if (q.size() != 0 && q[0].first) m_wones = q[0].ones;
    end
  end

  task automatic test_reset();
    reset = 0; in_valid = 1; in_data = 8'hFF;
    repeat (3) begin
      @(negedge clk);
      vectors++;
      if ({bit_out, bit_valid, bit_last, word_ones, total_ones, busy, in_ready} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got out=%b v=%b l=%b wo=%0d tot=%0d busy=%b rdy=%b, expected all 0",
                 bit_out, bit_valid, bit_last, word_ones, total_ones, busy, in_ready);
      end
    end
    reset = 1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", in_ready); end
    @(negedge clk);
    in_valid = 0;
    vectors++;
    if (bit_valid !== 1'b1 || bit_out !== 1'b1) begin
      errors++; $display("FAIL first_word_start: got v=%b out=%b expected v=1 out=1", bit_valid, bit_out);
    end
    repeat (8) @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || total_ones !== 16'd8) begin
      errors++; $display("FAIL first_word_done: got busy=%b tot=%0d expected busy=0 tot=8", busy, total_ones);
    end
  endtask

  task automatic test_single();
    logic [W-1:0] w;
    int t0;
    w = 8'hA5;
    t0 = m_total;
    in_valid = 1; in_data = w;
    @(negedge clk);
    in_valid = 0;
    for (int i = 0; i < W; i++) begin
      vectors++;
      if (bit_valid !== 1'b1 || bit_out !== w[i] || bit_last !== (i == W - 1)) begin
        errors++;
        $display("FAIL single_bit%0d: got v=%b out=%b last=%b expected v=1 out=%b last=%b",
                 i, bit_valid, bit_out, bit_last, w[i], i == W - 1);
      end
      @(negedge clk);
    end
    vectors++;
    if (busy !== 1'b0 || bit_valid !== 1'b0 || word_ones !== 4'd4 || total_ones !== 16'(t0 + 4)) begin
      errors++;
      $display("FAIL single_end: got busy=%b v=%b wo=%0d tot=%0d expected busy=0 v=0 wo=4 tot=%0d",
               busy, bit_valid, word_ones, total_ones, t0 + 4);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words [3];
    int k, t0, nv, nlow, first_v, last_v;
    logic will;
    words[0] = 8'h0F; words[1] = 8'hF0; words[2] = 8'hFF;
    k = 0; nv = 0; nlow = 0; first_v = -1; last_v = -1;
    t0 = m_total;
    in_valid = 1; in_data = words[0];
    for (int c = 1; c <= 30; c++) begin
      will = in_valid && m_ready();
      @(negedge clk);
      if (will) begin
        k++;
        if (k < 3) in_data = words[k]; else in_valid = 0;
      end
      vectors += 3;
      if (bit_valid !== (q.size() != 0)) begin
        errors++; $display("FAIL b2b_valid c%0d: got %b expected %b", c, bit_valid, q.size() != 0);
      end
      if (in_ready !== m_ready()) begin
        errors++; $display("FAIL b2b_ready c%0d: got %b expected %b", c, in_ready, m_ready());
      end
      if (word_ones !== m_wones[3:0]) begin
        errors++; $display("FAIL b2b_word_ones c%0d: got %0d expected %0d", c, word_ones, m_wones);
      end
      if (!in_ready) nlow++;
      if (bit_valid) begin
        nv++;
        if (first_v < 0) first_v = c;
        last_v = c;
      end
    end
    vectors += 3;
    if (nv != 24 || last_v - first_v + 1 != 24) begin
      errors++; $display("FAIL b2b_stream: got %0d valid over span %0d expected 24 over 24", nv, last_v - first_v + 1);
    end
    if (nlow != 14) begin errors++; $display("FAIL b2b_hold_full: got %0d ready-low cycles expected 14", nlow); end
    if (word_ones !== 4'd8 || total_ones !== 16'(t0 + 16)) begin
      errors++; $display("FAIL b2b_totals: got wo=%0d tot=%0d expected wo=8 tot=%0d", word_ones, total_ones, t0 + 16);
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 1; in_data = 8'hFF;
    @(negedge clk);
    in_data = 8'h55;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (bit_valid !== 1'b1 || busy !== 1'b1) begin
      errors++; $display("FAIL midreset_pre: got v=%b busy=%b expected 1 1", bit_valid, busy);
    end
    reset = 0;
    @(negedge clk);
    vectors++;
    if (bit_valid !== 1'b0 || total_ones !== 16'd0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_stop: got v=%b tot=%0d busy=%b rdy=%b expected 0 0 0 0", bit_valid, total_ones, busy, in_ready);
    end
    reset = 1;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b expected 1", in_ready); end
    repeat (10) begin
      @(negedge clk);
      vectors++;
      if (bit_valid !== 1'b0 || total_ones !== 16'd0) begin
        errors++; $display("FAIL midreset_dropped: got v=%b tot=%0d expected v=0 tot=0", bit_valid, total_ones);
      end
    end
  endtask

  task automatic test_gap();
    int t0;
    t0 = m_total;
    in_valid = 1; in_data = 8'h01;
    for (int c = 1; c <= 22; c++) begin
      @(negedge clk);
      vectors += 2;
      if (bit_valid !== (q.size() != 0)) begin
        errors++; $display("FAIL gap_valid c%0d: got %b expected %b", c, bit_valid, q.size() != 0);
      end
      if (word_ones !== 4'd1) begin errors++; $display("FAIL gap_word_ones c%0d: got %0d expected 1", c, word_ones); end
      if (bit_valid) begin
        vectors++;
        if (bit_out !== (c == 1 || c == 21) || bit_last !== (c == 8 || c == 21)) begin
          errors++;
          $display("FAIL gap_bits c%0d: got out=%b last=%b expected out=%b last=%b",
                   c, bit_out, bit_last, c == 1 || c == 21, c == 8 || c == 21);
        end
      end
      in_valid = (c == 13);
      in_data = 8'h80;
    end
    vectors++;
    if (total_ones !== 16'(t0 + 2)) begin
      errors++; $display("FAIL gap_total: got %0d expected %0d", total_ones, t0 + 2);
    end
  endtask

  task automatic test_saturate();
    int acc, exp, nv;
    acc = 0; exp = 0; nv = 0;
    r4 = 1; v4 = 1; d4 = 8'hFF;
    #1;
    for (int c = 1; c <= 28; c++) begin
      if (v4 && o4_ready) acc++;
      @(negedge clk);
      if (acc == 3) v4 = 0;
      vectors++;
      if (o4_total !== exp[3:0]) begin errors++; $display("FAIL sat_total c%0d: got %0d expected %0d", c, o4_total, exp); end
      if (c == 20) begin
        vectors++;
        if (o4_total !== 4'd15 || o4_valid !== 1'b1 || o4_out !== 1'b1) begin
          errors++; $display("FAIL sat_hold: got tot=%0d v=%b out=%b expected 15 1 1", o4_total, o4_valid, o4_out);
        end
      end
      if (o4_valid) nv++;
      c4 = (c == 20);
      exp = c4 ? 0 : (o4_valid && o4_out && exp < 15) ? exp + 1 : exp;
    end
    c4 = 0;
    vectors++;
    if (nv != 24) begin errors++; $display("FAIL sat_bits: got %0d valid cycles expected 24", nv); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      vectors += 6;
      if (bit_valid !== (q.size() != 0)) begin
        errors++; $display("FAIL rnd_valid c%0d: got %b expected %b", c, bit_valid, q.size() != 0);
      end
      if (q.size() != 0 && bit_out !== q[0].b) begin
        errors++; $display("FAIL rnd_bit c%0d: got %b expected %b", c, bit_out, q[0].b);
      end
      if (bit_last !== (q.size() != 0 && q[0].last)) begin
        errors++; $display("FAIL rnd_last c%0d: got %b expected %b", c, bit_last, q.size() != 0 && q[0].last);
      end
      if (in_ready !== m_ready() || busy !== (q.size() != 0)) begin
        errors++; $display("FAIL rnd_ready_busy c%0d: got rdy=%b busy=%b expected rdy=%b busy=%b",
                           c, in_ready, busy, m_ready(), q.size() != 0);
      end
      if (word_ones !== m_wones[3:0]) begin
        errors++; $display("FAIL rnd_word_ones c%0d: got %0d expected %0d", c, word_ones, m_wones);
      end
      if (total_ones !== m_total[15:0]) begin
        errors++; $display("FAIL rnd_total c%0d: got %0d expected %0d", c, total_ones, m_total);
      end
      reset = $urandom_range(0, 79) != 0;
      in_valid = $urandom_range(0, 3) != 0;
      in_data = 8'($urandom);
      clear_total = $urandom_range(0, 15) == 0;
    end
    reset = 1; in_valid = 0; clear_total = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_gap();
    test_saturate();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
